// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions used by the hazard and forwarding blocks.
package hazard_scoreboard_pkg;

    localparam int unsigned AW       = 5;
    localparam int unsigned NREG     = 32;
    localparam int unsigned LOAD_LAT = 1;
    localparam int unsigned MAX_INFL = 3;
    localparam int unsigned CW       = 2;

    typedef logic [AW-1:0] reg_idx_t;
    typedef logic [CW-1:0] cnt_t;

    // Register 0 is hardwired zero and never carries a dependency.
    function automatic logic is_tracked(input reg_idx_t idx);
        return idx != '0;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One architectural register's in-flight writer count and forwarding countdown.
module hazard_scoreboard_sb_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned LoadLat = LOAD_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic issue,
    input  logic issue_load,
    input  logic retire,
    output cnt_t infl,
    output cnt_t rdy_cnt
);

    cnt_t infl_q, infl_d;
    cnt_t rdy_q, rdy_d;
    logic retire_eff;

    // A writeback to an idle register is ignored so the count never underflows.
    assign retire_eff = retire & (infl_q != '0);

    // Next-state: issue/retire bookkeeping, countdown, flush wins over everything.
    always_comb begin
        infl_d = infl_q;
        rdy_d  = (rdy_q != '0) ? rdy_q - cnt_t'(1) : rdy_q;
        if (flush) begin
            infl_d = '0;
            rdy_d  = '0;
        end else begin
            if (issue && !retire_eff) begin
                infl_d = infl_q + cnt_t'(1);
            end else if (!issue && retire_eff) begin
                infl_d = infl_q - cnt_t'(1);
                if (infl_q == cnt_t'(1)) begin
                    rdy_d = '0;
                end
            end
            // The youngest writer owns the countdown.
            if (issue) begin
                rdy_d = issue_load ? cnt_t'(LoadLat) : '0;
            end
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_q <= '0;
            rdy_q  <= '0;
        end else begin
            infl_q <= infl_d;
            rdy_q  <= rdy_d;
        end
    end

    assign infl    = infl_q;
    assign rdy_cnt = rdy_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-pending scoreboard: tracks in-flight destinations and stalls ID on
// unforwardable source operands or per-register writer overflow.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs1,
    input  logic [AW-1:0]   id_rs2,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_we,
    input  logic            id_is_load,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic            flush,
    output logic            stall,
    output logic            id_fire,
    output logic [NREG-1:0] pending
);

    cnt_t infl    [NREG];
    cnt_t rdy_cnt [NREG];
    logic haz_rs1, haz_rs2, haz_ovf;

    assign infl[0]    = '0;
    assign rdy_cnt[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        logic issue_r, retire_r;
        assign issue_r  = id_fire & id_we & (id_rd == reg_idx_t'(r));
        assign retire_r = wb_valid & (wb_rd == reg_idx_t'(r));

        hazard_scoreboard_sb_entry #(
            .LoadLat (LOAD_LAT)
        ) u_sb_entry (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (flush),
            .issue      (issue_r),
            .issue_load (id_is_load),
            .retire     (retire_r),
            .infl       (infl[r]),
            .rdy_cnt    (rdy_cnt[r])
        );
    end

    // Pending flags straight from the writer counts.
    always_comb begin
        pending = '0;
        for (int r = 0; r < NREG; r++) begin
            pending[r] = (infl[r] != '0);
        end
    end

    // Source and overflow hazards; a same-cycle WB to id_rd frees a slot.
    always_comb begin
        haz_rs1 = id_rs1_used & is_tracked(id_rs1) & pending[id_rs1] &
                  (rdy_cnt[id_rs1] != '0);
        haz_rs2 = id_rs2_used & is_tracked(id_rs2) & pending[id_rs2] &
                  (rdy_cnt[id_rs2] != '0);
        haz_ovf = id_we & is_tracked(id_rd) & (infl[id_rd] == cnt_t'(MAX_INFL)) &
                  ~(wb_valid & (wb_rd == id_rd));
        stall   = id_valid & (haz_rs1 | haz_rs2 | haz_ovf);
    end

    assign id_fire = id_valid & ~stall;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Register-pending scoreboard for the hazard-handling 5-stage pipeline. The forwarding path consumes in-flight results. This block is the producer-side tracker. It records every destination register issued from ID, counts down until each result becomes forwardable, and clears the entry at writeback. It raises a stall to ID when a source operand's producer cannot yet be forwarded (load-use or multi-cycle latency). It also stalls when per-register tracking would overflow.

## Interface
- `NREG`, 32, architectural register count; register 0 is hardwired zero and never tracked
- `AW`, 5, register index width
- `LOAD_LAT`, 1, cycles after issue before a load result is forwardable (1..3)
- `MAX_INFL`, 3, maximum in-flight writers per register (counter width 2)

Ports:
- `clk` in 1: the single clock, rising edge
- `rst_n` in 1: reset, asynchronous assert, active-low
- `id_valid` in 1: ID holds a valid instruction
- `id_rs1`, `id_rs2` in AW: source indices
- `id_rs1_used`, `id_rs2_used` in 1: source actually read
- `id_rd` in AW: destination index
- `id_we` in 1: instruction writes `id_rd`
- `id_is_load` in 1: producer has `LOAD_LAT` latency; otherwise forwardable next cycle
- `wb_valid` in 1: a writeback retires this cycle
- `wb_rd` in AW: retiring destination
- `flush` in 1: squash all younger-than-WB instructions
- `stall` out 1: hold ID/IF; insert bubble into EX
- `id_fire` out 1: `id_valid & ~stall`; the issue event
- `pending` out NREG: bit r set iff register r has ≥1 in-flight writer

## Operation
- Per-register state:
  - `infl[r]` (2 bits): count of in-flight writers.
  - `rdy_cnt[r]` (2 bits): cycles until the youngest writer's value is forwardable.
- `pending[r] = (infl[r] != 0)`.
- Source hazard on rsN: `id_rsN_used & (id_rsN != 0) & pending[id_rsN] & (rdy_cnt[id_rsN] != 0)`.
- Overflow hazard: `id_we & (id_rd != 0) & (infl[id_rd] == MAX_INFL)` and no simultaneous `wb_valid` with `wb_rd == id_rd`.
- `stall = id_valid & (src hazard rs1 | src hazard rs2 | overflow hazard)`. It is combinational from registered state and ID inputs.
- On `id_fire & id_we & id_rd != 0`:
  - `infl[id_rd]` increments.
  - `rdy_cnt[id_rd]` loads `LOAD_LAT` if `id_is_load`, else 0.
- Every cycle, each nonzero `rdy_cnt` not being reloaded decrements by 1.
- On `wb_valid & wb_rd != 0`: `infl[wb_rd]` decrements.
  - When it reaches 0, `rdy_cnt[wb_rd]` is forced to 0.
  - A WB to a register with `infl == 0` is ignored: no underflow, no change.
- Same cycle, same register, issue and WB: net `infl` is unchanged, and `rdy_cnt` takes the issue value.
- `flush`: all `infl` and `rdy_cnt` clear next edge. `flush` overrides issue and WB that cycle. `stall` is still computed from current state.
- Writes to or reads of register 0 never set state or cause a stall.

## Timing
- Reset: all `infl`, `rdy_cnt` = 0. `pending` = 0. `stall` = 0 and `id_fire` = `id_valid` while state is clear.
- `stall` has zero latency (same cycle as ID inputs). State updates at the next rising edge.
- Load-use with `LOAD_LAT=1`: a dependent instruction in the very next ID cycle sees exactly 1 stall cycle. It fires on the following cycle.
- An ALU producer never causes a stall.
- `pending[r]` rises the cycle after issue. It falls the cycle after the last matching WB.
- Asynchronous reset mid-operation clears all state immediately. `stall` drops with it.

## Structure
- Shared pipeline package: `AW`, `NREG`, and `LOAD_LAT` as localparams, plus a `reg_idx_t` typedef. The forwarding and hazard blocks share these.
- One natural sub-module, `sb_entry`: one register's `infl` and `rdy_cnt` plus their update logic. It is instantiated `NREG-1` times by generate.
- The top level holds the source/overflow compare muxes and `stall` only.

## Test plan
- After reset with no pending writers, `id_valid=1`, `rs1=5`: `stall=0`, `id_fire=1`, `pending=0`.
- Load to r3 issues at cycle t, and the next ID instruction reads r3 at t+1: `stall=1` at t+1, `stall=0` at t+2, and it fires at t+2. An ALU write to r3 at t gives no stall at t+1.
- Three writers to r7 in flight, and a fourth tries to issue: `stall=1` until a WB to r7, which lets it fire in that same cycle with `infl[7]` staying 3.
- Issue writing r4 and WB of r4 in the same cycle with `infl[4]=1`: `infl[4]` stays 1 and `pending[4]` stays 1. A WB to r9 with `infl[9]=0` is a no-op.
- `flush` with several registers pending and a simultaneous issue: all `pending=0` next cycle, and the issue is not recorded.
- An instruction with `rd=0` (load) followed by one reading r0, and `rst_n` asserted mid-stall: no stall from r0. During reset `stall` drops immediately and `pending=0`.
